// File: rtl/rc_channel_poller.sv
// rc_channel_poller: periodically reads NUM_CH RC pulse widths over Wishbone, publishes good ones and tracks link failsafe
module rc_channel_poller #(
    parameter int POLL_CYCLES = 2_000_000,
    parameter int NUM_CH      = 6,
    parameter int MIN_US      = 900,
    parameter int MAX_US      = 2100,
    parameter int ACK_TIMEOUT = 16,
    parameter int FS_POLLS    = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [31:0]          wb_adr_o,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_we_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic                 wb_cyc_o,
    output logic [16*NUM_CH-1:0] o_ch,
    output logic [NUM_CH-1:0]    o_bad_mask,
    output logic                 o_valid,
    output logic                 o_failsafe
);
    localparam int CW = $clog2(POLL_CYCLES);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int BW = $clog2(FS_POLLS + 1);
    localparam logic [15:0] MIN_W = 16'(MIN_US);
    localparam logic [15:0] MAX_W = 16'(MAX_US);
    localparam logic [16*NUM_CH-1:0] CH_RST = {NUM_CH{16'd1500}};

    typedef enum logic [1:0] {IDLE, REQ, NEXT, PUBLISH} state_t;

    state_t                state;
    logic [CW-1:0]         tcnt;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tmo;
    logic [BW-1:0]         bcnt, bcnt_n;
    logic [16*NUM_CH-1:0]  stage;
    logic [NUM_CH-1:0]     stage_bad;
    logic                  tick, done, good;
    logic                  unused_hi;

    assign wb_we_o   = 1'b0;
    assign wb_dat_o  = '0;
    assign unused_hi = ^wb_dat_i[31:16];

    always_comb begin
        tick   = tcnt == CW'(POLL_CYCLES - 1);
        done   = wb_err_i || wb_ack_i || tmo == TW'(ACK_TIMEOUT);
        good   = wb_ack_i && !wb_err_i && wb_dat_i[15:0] >= MIN_W && wb_dat_i[15:0] <= MAX_W;
        bcnt_n = |stage_bad ? (bcnt == BW'(FS_POLLS) ? bcnt : bcnt + 1'b1) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            idx        <= '0;
            tmo        <= '0;
            bcnt       <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_sel_o   <= '0;
            wb_adr_o   <= '0;
            stage      <= CH_RST;
            stage_bad  <= '1;
            o_ch       <= CH_RST;
            o_bad_mask <= '1;
            o_valid    <= 1'b0;
            o_failsafe <= 1'b1;
        end else begin
            tcnt    <= tick ? '0 : tcnt + 1'b1;
            o_valid <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state     <= REQ;
                    idx       <= '0;
                    tmo       <= TW'(1);
                    wb_cyc_o  <= 1'b1;
                    wb_stb_o  <= 1'b1;
                    wb_sel_o  <= 4'hF;
                    wb_adr_o  <= '0;
                    stage     <= o_ch;
                    stage_bad <= '0;
                end
                REQ: if (done) begin
                    state    <= NEXT;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_sel_o <= '0;
                    if (good) stage[16*idx +: 16] <= wb_dat_i[15:0];
                    else stage_bad[idx] <= 1'b1;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                NEXT: if (idx == IW'(NUM_CH - 1)) begin
                    state <= PUBLISH;
                end else begin
                    state    <= REQ;
                    idx      <= idx + 1'b1;
                    tmo      <= TW'(1);
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_sel_o <= 4'hF;
                    wb_adr_o <= 32'({idx + 1'b1, 2'b00});
                end
                PUBLISH: begin
                    state      <= IDLE;
                    o_ch       <= stage;
                    o_bad_mask <= stage_bad;
                    o_valid    <= 1'b1;
                    bcnt       <= bcnt_n;
                    o_failsafe <= bcnt_n >= BW'(FS_POLLS);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc_channel_poller.sv
// tb_rc_channel_poller: randomized Wishbone slave plus a per-poll reference model of the published channel state
module tb_rc_channel_poller;
    localparam int P   = 200;
    localparam int P2  = 50;
    localparam int NCH = 6;
    localparam int TO  = 16;
    localparam int FS  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    logic rst_q = 1'b1;

    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [16*NCH-1:0] o_ch;
    logic [NCH-1:0]    o_bad_mask;
    logic              o_valid, o_failsafe;

    logic [31:0] b_adr, b_dat_o;
    logic        b_we, b_stb, b_cyc, b_valid, b_fs;
    logic [3:0]  b_sel;
    logic [16*NCH-1:0] b_ch;
    logic [NCH-1:0]    b_mask;

    rc_channel_poller #(.POLL_CYCLES(P), .NUM_CH(NCH), .ACK_TIMEOUT(TO), .FS_POLLS(FS)) dut (
        .i_clk(clk), .i_rst(rst),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_cyc_o(wb_cyc_o), .o_ch(o_ch), .o_bad_mask(o_bad_mask), .o_valid(o_valid),
        .o_failsafe(o_failsafe)
    );

    rc_channel_poller #(.POLL_CYCLES(P2), .NUM_CH(NCH), .ACK_TIMEOUT(TO), .FS_POLLS(FS)) dut_fast (
        .i_clk(clk), .i_rst(rst),
        .wb_adr_o(b_adr), .wb_dat_i(32'h0), .wb_dat_o(b_dat_o), .wb_we_o(b_we),
        .wb_sel_o(b_sel), .wb_stb_o(b_stb), .wb_ack_i(1'b0), .wb_err_i(1'b0),
        .wb_cyc_o(b_cyc), .o_ch(b_ch), .o_bad_mask(b_mask), .o_valid(b_valid),
        .o_failsafe(b_fs)
    );

    int n_checks = 0;
    int n_fail = 0;

    // slave behaviour per channel: 0 ack, 1 err, 2 silent (late ack after drop), 3 ack+err
    int          mode[NCH];
    int          lat[NCH];
    logic [15:0] width[NCH];
    int          read_len[NCH];
    int          gap[NCH];
    int          wcnt = 0;
    int          idle = 0;
    int          cur = 0;

    int          exp_ch[NCH];
    logic [NCH-1:0] exp_mask;
    int          exp_bcnt;
    logic        exp_fs;

    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (wcnt == 0) begin
                cur = int'(wb_adr_o >> 2);
                if (cur >= NCH) cur = NCH - 1;
                gap[cur] = idle;
            end
            wcnt++;
            wb_ack_i = wcnt == lat[cur] && (mode[cur] == 0 || mode[cur] == 3);
            wb_err_i = wcnt == lat[cur] && (mode[cur] == 1 || mode[cur] == 3);
            wb_dat_i = {16'($urandom), width[cur]};
            idle = 0;
        end else begin
            if (wcnt > 0) read_len[cur] = wcnt;
            wb_ack_i = wcnt > 0 && mode[cur] == 2;
            wb_err_i = 1'b0;
            wb_dat_i = {16'($urandom), 16'd1234};
            wcnt = 0;
            idle++;
        end
    end

    always @(posedge clk) rst_q <= rst;

    logic [16*NCH-1:0] prev_ch;
    logic [NCH-1:0]    prev_mask;
    always @(negedge clk) begin
        if (!rst_q && (o_ch !== prev_ch || o_bad_mask !== prev_mask)) begin
            n_checks++;
            if (o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL outputs_outside_publish: o_ch/o_bad_mask changed with o_valid=%b, required 1", o_valid);
            end
        end
        prev_ch = o_ch;
        prev_mask = o_bad_mask;
    end

    function automatic logic [16*NCH-1:0] exp_vec();
        for (int c = 0; c < NCH; c++) exp_vec[16*c +: 16] = 16'(exp_ch[c]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) exp_ch[c] = 1500;
        exp_mask = '1;
        exp_bcnt = 0;
        exp_fs = 1'b1;
    endtask

    task automatic set_all(input int m, input int w, input int l);
        for (int c = 0; c < NCH; c++) begin
            mode[c] = m;
            width[c] = 16'(w);
            lat[c] = l;
        end
    endtask

    task automatic do_poll(output bit ok);
        bit g;
        ok = 1'b0;
        for (int i = 0; i < 3*P; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int c = 0; c < NCH; c++) begin
                g = mode[c] == 0 && int'(width[c]) >= 900 && int'(width[c]) <= 2100;
                if (g) exp_ch[c] = int'(width[c]);
                exp_mask[c] = !g;
            end
            exp_bcnt = |exp_mask ? (exp_bcnt < FS ? exp_bcnt + 1 : FS) : 0;
            exp_fs = exp_bcnt >= FS;
        end
    endtask

    task automatic test_reset();
        int n;
        n_checks++;
        if (o_ch !== {NCH{16'd1500}}) begin n_fail++; $display("FAIL reset_o_ch: got %h, expected %h", o_ch, {NCH{16'd1500}}); end
        n_checks++;
        if ({o_bad_mask, o_valid, o_failsafe} !== {6'h3F, 1'b0, 1'b1}) begin n_fail++; $display("FAIL reset_flags: mask/valid/fs got %h/%b/%b, expected 3f/0/1", o_bad_mask, o_valid, o_failsafe); end
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== '0) begin n_fail++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, expected all 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o); end
        width[0] = 16'd2000; width[1] = 16'd1900; width[2] = 16'd1800;
        width[3] = 16'd1600; width[4] = 16'd1500; width[5] = 16'd1000;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 2*P; i++) begin
            @(negedge clk);
            n++;
            if (wb_cyc_o) break;
        end
        n_checks++;
        if (n !== P) begin n_fail++; $display("FAIL first_tick: poll started %0d clocks after release, expected %0d", n, P); end
        n_checks++;
        if ({wb_stb_o, wb_sel_o, wb_we_o, wb_adr_o} !== {1'b1, 4'hF, 1'b0, 32'h0}) begin n_fail++; $display("FAIL req_bus: stb=%b sel=%h we=%b adr=%h, expected 1/f/0/0", wb_stb_o, wb_sel_o, wb_we_o, wb_adr_o); end
    endtask

    task automatic test_basic();
        bit ok;
        do_poll(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done: o_valid not seen, expected a pulse"); end
        n_checks++;
        if (o_ch !== {16'd1000, 16'd1500, 16'd1600, 16'd1800, 16'd1900, 16'd2000}) begin n_fail++; $display("FAIL basic_o_ch: got %h, expected %h", o_ch, {16'd1000, 16'd1500, 16'd1600, 16'd1800, 16'd1900, 16'd2000}); end
        n_checks++;
        if ({o_bad_mask, o_failsafe} !== 7'b0) begin n_fail++; $display("FAIL basic_flags: mask=%h fs=%b, expected 00/0", o_bad_mask, o_failsafe); end
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL valid_width: o_valid=%b on second clock, expected 0", o_valid); end
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if (read_len[c] !== 2) begin n_fail++; $display("FAIL read_len ch%0d: stb high %0d clocks, expected 2", c, read_len[c]); end
            if (c > 0) begin
                n_checks++;
                if (gap[c] !== 1) begin n_fail++; $display("FAIL bus_gap ch%0d: idle %0d clocks, expected 1", c, gap[c]); end
            end
        end
    endtask

    task automatic test_range();
        bit ok;
        int seq[4] = '{899, 2101, 900, 2100};
        for (int k = 0; k < 4; k++) begin
            width[5] = 16'(seq[k]);
            do_poll(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL range_done %0d: o_valid not seen", seq[k]); end
            n_checks++;
            if (o_ch[95:80] !== 16'(exp_ch[5]) || o_bad_mask[5] !== exp_mask[5]) begin n_fail++; $display("FAIL range %0d: lane5=%0d bad=%b, expected %0d/%b", seq[k], o_ch[95:80], o_bad_mask[5], exp_ch[5], exp_mask[5]); end
            n_checks++;
            if (o_ch !== exp_vec()) begin n_fail++; $display("FAIL range_o_ch %0d: got %h, expected %h", seq[k], o_ch, exp_vec()); end
        end
    endtask

    task automatic test_ack_err();
        bit ok;
        mode[2] = 3;
        width[2] = 16'd1750;
        do_poll(ok);
        n_checks++;
        if (!ok || o_bad_mask !== 6'b000100) begin n_fail++; $display("FAIL ack_err_mask: done=%b mask=%b, expected 1/000100", ok, o_bad_mask); end
        n_checks++;
        if (o_ch[47:32] !== 16'(exp_ch[2]) || o_ch !== exp_vec()) begin n_fail++; $display("FAIL ack_err_lane2: got %h, expected %h", o_ch, exp_vec()); end
        mode[2] = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        set_all(2, 1500, 2);
        for (int k = 0; k < 3; k++) begin
            do_poll(ok);
            n_checks++;
            if (!ok || o_bad_mask !== 6'h3F || o_ch !== exp_vec()) begin n_fail++; $display("FAIL timeout_poll %0d: done=%b mask=%h o_ch=%h, expected 1/3f/%h", k, ok, o_bad_mask, o_ch, exp_vec()); end
            n_checks++;
            if (o_failsafe !== exp_fs) begin n_fail++; $display("FAIL failsafe_poll %0d: got %b, expected %b", k, o_failsafe, exp_fs); end
        end
        for (int c = 0; c < NCH; c++) begin
            n_checks++;
            if (read_len[c] !== TO) begin n_fail++; $display("FAIL timeout_len ch%0d: stb high %0d clocks, expected %0d", c, read_len[c], TO); end
        end
        set_all(0, 1500, 2);
        do_poll(ok);
        n_checks++;
        if (!ok || {o_bad_mask, o_failsafe} !== 7'b0) begin n_fail++; $display("FAIL failsafe_clear: done=%b mask=%h fs=%b, expected 1/00/0", ok, o_bad_mask, o_failsafe); end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < NCH; c++) begin
                r = $urandom_range(8, 0);
                mode[c] = r < 6 ? 0 : r - 5;
                width[c] = 16'($urandom_range(2200, 800));
                lat[c] = $urandom_range(5, 1);
            end
            do_poll(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL random_done %0d: o_valid not seen", k); end
            n_checks++;
            if (o_ch !== exp_vec()) begin n_fail++; $display("FAIL random_o_ch %0d: got %h, expected %h", k, o_ch, exp_vec()); end
            n_checks++;
            if (o_bad_mask !== exp_mask || o_failsafe !== exp_fs) begin n_fail++; $display("FAIL random_flags %0d: mask=%b fs=%b, expected %b/%b", k, o_bad_mask, o_failsafe, exp_mask, exp_fs); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int n, nv;
        set_all(0, 1600, 3);
        found = 1'b0;
        for (int i = 0; i < 3*P; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_adr_o == 32'd12) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL mid_find: read of index 3 not seen"); end
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, o_valid} !== 3'b0) begin n_fail++; $display("FAIL mid_bus: cyc=%b stb=%b valid=%b, expected 0/0/0", wb_cyc_o, wb_stb_o, o_valid); end
        n_checks++;
        if (o_ch !== exp_vec() || o_failsafe !== 1'b1) begin n_fail++; $display("FAIL mid_outputs: o_ch=%h fs=%b, expected %h/1", o_ch, o_failsafe, exp_vec()); end
        rst = 1'b0;
        n = 0;
        nv = 0;
        for (int i = 0; i < 2*P; i++) begin
            @(negedge clk);
            n++;
            if (o_valid) nv++;
            if (wb_cyc_o) break;
        end
        n_checks++;
        if (n !== P || nv !== 0) begin n_fail++; $display("FAIL mid_restart: start after %0d clocks with %0d valid pulses, expected %0d/0", n, nv, P); end
        do_poll(ok);
        n_checks++;
        if (!ok || o_ch !== exp_vec() || o_failsafe !== 1'b0) begin n_fail++; $display("FAIL mid_recover: done=%b o_ch=%h fs=%b, expected 1/%h/0", ok, o_ch, o_failsafe, exp_vec()); end
    endtask

    task automatic test_drop();
        bit seen;
        int n, rises, period;
        logic pc;
        // polls may only begin on a tick that lands after the previous poll has returned to idle
        period = ((NCH*(TO+1) + 1 + P2) / P2) * P2;
        seen = 1'b0;
        for (int i = 0; i < 8*P2; i++) begin
            @(negedge clk);
            if (b_valid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL drop_first: fast poller o_valid not seen"); end
        n = 0;
        rises = 0;
        pc = b_cyc;
        seen = 1'b0;
        for (int i = 0; i < 8*P2; i++) begin
            @(negedge clk);
            n++;
            if (b_cyc && !pc) rises++;
            pc = b_cyc;
            if (b_valid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen || n !== period) begin n_fail++; $display("FAIL drop_period: valid spacing %0d (seen=%b), expected %0d", n, seen, period); end
        n_checks++;
        if (rises !== NCH || b_mask !== 6'h3F) begin n_fail++; $display("FAIL drop_reads: %0d bus cycles mask=%h, expected %0d/3f", rises, b_mask, NCH); end
    endtask

    initial begin
        set_all(0, 1500, 2);
        repeat (3) @(negedge clk);
        model_reset();
        test_reset();
        test_basic();
        test_range();
        test_ack_err();
        test_timeout();
        test_random();
        test_reset_mid();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rc_channel_poller.md
RC_CHANNEL_POLLER -- requirements
Module: rc_channel_poller

Interface
REQ-001 The block SHALL have parameter POLL_CYCLES, default 2_000_000, meaning clocks between poll starts (50 Hz at 100 MHz).
REQ-002 The block SHALL have parameter NUM_CH, default 6, meaning decoder channels read per poll, at word addresses 0..NUM_CH-1.
REQ-003 The block SHALL have parameter MIN_US, default 900, meaning the lowest accepted pulse width in microseconds.
REQ-004 The block SHALL have parameter MAX_US, default 2100, meaning the highest accepted pulse width in microseconds.
REQ-005 The block SHALL have parameter ACK_TIMEOUT, default 16, meaning the clocks to wait for ack or err before abandoning a read.
REQ-006 The block SHALL have parameter FS_POLLS, default 3, meaning consecutive bad polls before failsafe.
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-008 The block SHALL have port i_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-009 The block SHALL have ports wb_adr_o (output, 32), wb_dat_i (input, 32), wb_dat_o (output, 32), wb_we_o (output, 1), wb_sel_o (output, 4), wb_stb_o (output, 1), wb_ack_i (input, 1), wb_err_i (input, 1) and wb_cyc_o (output, 1), forming the Wishbone classic master to the PWM decoder slave.
REQ-010 The block SHALL have port o_ch, output, 16*NUM_CH bits: the last good width per channel in microseconds, with channel n at bits [16n+15:16n].
REQ-011 The block SHALL have port o_bad_mask, output, NUM_CH bits: bit n set when channel n failed in the last completed poll.
REQ-012 The block SHALL have port o_valid, output, 1 bit: a one-clock pulse when a poll completes.
REQ-013 The block SHALL have port o_failsafe, output, 1 bit: asserted while the RC link is considered lost.

Function
REQ-014 A free-running tick counter SHALL issue a poll start every POLL_CYCLES clocks; a tick arriving while a poll is in progress SHALL be dropped, not queued.
REQ-015 The FSM states SHALL be IDLE, REQ, NEXT and PUBLISH.
REQ-016 The FSM SHALL go from IDLE to REQ on a tick, with the channel index set to 0.
REQ-017 In REQ the block SHALL drive wb_cyc_o=1, wb_stb_o=1, wb_we_o=0, wb_sel_o=4'b1111, wb_adr_o=index<<2 and wb_dat_o=0.
REQ-018 REQ SHALL exit to NEXT on the first clock where wb_ack_i, wb_err_i or the timeout expires.
REQ-019 In the transition out of REQ, wb_cyc_o and wb_stb_o SHALL be deasserted on the clock after ack, so each read is exactly one bus cycle.
REQ-020 If ack and err are both high on the same clock, err SHALL take priority and the channel SHALL be bad.
REQ-021 A channel SHALL be good only when ack is received and MIN_US <= wb_dat_i[15:0] <= MAX_US, both bounds inclusive.
REQ-022 A channel SHALL be bad on err, on timeout, or when the width is out of range.
REQ-023 wb_dat_i[31:16] SHALL be ignored.
REQ-024 A good channel SHALL be written to a staging register; a bad channel SHALL set its staging bad bit and leave its staged value equal to the previous o_ch value.
REQ-025 NEXT SHALL increment the index and return to REQ, or go to PUBLISH after index NUM_CH-1.
REQ-026 In NEXT the bus SHALL be idle for exactly one clock between reads.
REQ-027 PUBLISH SHALL copy the staging registers to o_ch and o_bad_mask, pulse o_valid for one clock, update failsafe, and return to IDLE.
REQ-028 o_ch and o_bad_mask SHALL never change outside PUBLISH.
REQ-029 Failsafe SHALL use a saturating bad-poll counter: increment when any bit is set in the new mask, otherwise clear to 0.
REQ-030 o_failsafe SHALL be 1 when the bad-poll counter is >= FS_POLLS, and SHALL clear in the same PUBLISH as the first fully good poll.
REQ-031 The timeout counter SHALL reset on entry to REQ and count from 1; at ACK_TIMEOUT it SHALL abandon the read, which counts as bad.
REQ-032 A late ack after a timeout SHALL be ignored, because the bus is deasserted by then.
REQ-033 Worst-case poll duration SHALL be NUM_CH*(ACK_TIMEOUT+1)+1 clocks, and SHALL be less than POLL_CYCLES.

Reset
REQ-034 When i_rst=1 at a clock edge, the block SHALL enter IDLE, clear the tick counter, index, timeout counter and bad-poll counter, and drive all wb_* outputs to 0.
REQ-035 On the same reset, the block SHALL set each o_ch lane to 1500, o_bad_mask to all ones, o_valid to 0 and o_failsafe to 1.
REQ-036 A reset mid-read SHALL drop wb_cyc_o and wb_stb_o on the next edge, discard staged data, and leave o_ch at the reset value of 1500 per lane.
REQ-037 The first tick after reset release SHALL occur POLL_CYCLES clocks later.

Verification
REQ-038 Slave model acks in 2 clocks with widths 2000, 1900, 1800, 1600, 1500 and 1000 -> one o_valid pulse, o_ch matches those widths, o_bad_mask=0, o_failsafe=0 after the first poll.
REQ-039 Channel 5 returns 899, then 2101, then 900 and 2100 -> the first two polls set mask bit 5 with o_ch lane 5 held at its prior value; 900 and 2100 are both accepted.
REQ-040 Slave never acks -> each read lasts 16 clocks with stb high, mask=6'h3F, and o_failsafe rises on the 3rd poll; one fully good poll afterwards clears it.
REQ-041 Slave asserts ack and err together on channel 2 -> mask=6'b000100, and lane 2 is unchanged.
REQ-042 i_rst pulsed while index=3 in REQ -> the bus goes idle the next clock, o_ch reads 1500 per lane, o_failsafe=1, and there is no o_valid pulse.
REQ-043 POLL_CYCLES=50 with ACK_TIMEOUT=16 and a non-acking slave -> ticks that arrive during an active poll are dropped, and polls never overlap.
